// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game core: countdown, LFSR-placed moles, edge-detected hits, saturating score.
// All outputs registered (1-cycle latency from inputs); no backpressure, start ignored while playing.
module mole_game_ctrl #(
    parameter int         CLK_HZ          = 100_000_000,
    parameter int         GAME_SECONDS    = 30,
    parameter int         MOLE_UP_CYCLES  = 75_000_000,
    parameter int         MOLE_GAP_CYCLES = 25_000_000,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn,
    output logic [5:0] timer,
    output logic [5:0] score,
    output logic [3:0] mole,
    output logic       game_over
);
    localparam int SEC_W = $clog2(CLK_HZ + 1);
    localparam int UP_W  = $clog2(MOLE_UP_CYCLES + 1);
    localparam int GAP_W = $clog2(MOLE_GAP_CYCLES + 1);
    localparam logic [5:0] TIMER_INIT = 6'(GAME_SECONDS);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
    typedef enum logic {GAP, UP} phase_t;

    state_t           state;
    phase_t           phase;
    logic [SEC_W-1:0] sec_cnt;
    logic [UP_W-1:0]  up_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       btn_prev;
    logic [7:0]       lfsr;
    logic [1:0]       prev_idx;

    logic       lfsr_fb;
    logic       hit;
    logic       sec_tick;
    logic       game_end;
    logic [1:0] idx_new;
    logic [5:0] score_inc;

    always_comb begin
        lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        hit       = (state == PLAY) && (phase == UP) && |(btn & ~btn_prev & mole);
        sec_tick  = (sec_cnt == SEC_W'(CLK_HZ - 1));
        game_end  = sec_tick && (timer == 6'd1);
        idx_new   = (lfsr[1:0] == prev_idx) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
        score_inc = (score == 6'd63) ? 6'd63 : score + 6'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            phase     <= GAP;
            sec_cnt   <= '0;
            up_cnt    <= '0;
            gap_cnt   <= '0;
            btn_prev  <= '0;
            lfsr      <= LFSR_SEED;
            prev_idx  <= '0;
            timer     <= TIMER_INIT;
            score     <= '0;
            mole      <= '0;
            game_over <= 1'b0;
        end else begin
            lfsr     <= {lfsr[6:0], lfsr_fb};
            btn_prev <= btn;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state     <= PLAY;
                        phase     <= GAP;
                        sec_cnt   <= '0;
                        up_cnt    <= '0;
                        gap_cnt   <= '0;
                        timer     <= TIMER_INIT;
                        score     <= '0;
                        mole      <= '0;
                        game_over <= 1'b0;
                    end
                end
                PLAY: begin
                    if (hit)
                        score <= score_inc;
                    if (sec_tick) begin
                        sec_cnt <= '0;
                        timer   <= timer - 6'd1;
                    end else begin
                        sec_cnt <= sec_cnt + SEC_W'(1);
                    end
                    // The final tick wins over any mole transition on the same edge.
                    if (game_end) begin
                        state     <= OVER;
                        phase     <= GAP;
                        mole      <= '0;
                        game_over <= 1'b1;
                    end else if (phase == GAP) begin
                        if (gap_cnt == GAP_W'(MOLE_GAP_CYCLES - 1)) begin
                            phase    <= UP;
                            up_cnt   <= '0;
                            mole     <= 4'b0001 << idx_new;
                            prev_idx <= idx_new;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end else begin
                        if (hit || (up_cnt == UP_W'(MOLE_UP_CYCLES - 1))) begin
                            phase   <= GAP;
                            gap_cnt <= '0;
                            mole    <= '0;
                        end else begin
                            up_cnt <= up_cnt + UP_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mole_game_ctrl.sv
// Scoreboard bench: the driver pushes the reference model's expected outputs per edge;
// a monitor pops and compares them shortly after each clock edge or reset assertion.
module tb_mole_game_ctrl;
    localparam int CLK_HZ = 10;
    localparam int GS     = 3;
    localparam int UPC    = 6;
    localparam int GAPC   = 2;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn   = 4'd0;
    logic [5:0] timer;
    logic [5:0] score;
    logic [3:0] mole;
    logic       game_over;

    mole_game_ctrl #(
        .CLK_HZ(CLK_HZ), .GAME_SECONDS(GS), .MOLE_UP_CYCLES(UPC),
        .MOLE_GAP_CYCLES(GAPC), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .btn(btn),
        .timer(timer), .score(score), .mole(mole), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] timer;
        logic [5:0] score;
        logic [3:0] mole;
        logic       over;
        logic [3:0] scen;
    } exp_t;

    exp_t q[$];
    exp_t got;
    int   checks = 0;
    int   errors = 0;
    int   scen   = 0;

    // Reference model: game state, cycles since game start, lit mole (-1 = none), phase age.
    int         m_state;
    int         play_t;
    int         m_score;
    int         lit;
    int         age;
    int         prev_idx;
    logic [7:0] m_lfsr;
    logic [3:0] m_bprev;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    function automatic logic [3:0] hit_btn();
        return (lit >= 0) ? 4'(1 << lit) : 4'd0;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        play_t   = 0;
        m_score  = 0;
        lit      = -1;
        age      = 0;
        prev_idx = 0;
        m_lfsr   = SEED;
        m_bprev  = 4'd0;
    endtask

    task automatic model_edge(input logic s, input logic [3:0] b);
        logic [3:0] edg;
        bit         hit;
        int         idx;
        edg = b & ~m_bprev;
        if (m_state != 1) begin
            if (s) begin
                m_state = 1;
                play_t  = 0;
                m_score = 0;
                lit     = -1;
                age     = 0;
            end
        end else begin
            hit = (lit >= 0) && edg[lit];
            if (hit && m_score < 63) m_score++;
            play_t++;
            if (play_t == GS * CLK_HZ) begin
                m_state = 2;
                lit     = -1;
            end else if (lit < 0) begin
                age++;
                if (age == GAPC) begin
                    idx = int'(m_lfsr[1:0]);
                    if (idx == prev_idx) idx = (idx + 1) % 4;
                    lit      = idx;
                    prev_idx = idx;
                    age      = 0;
                end
            end else begin
                age++;
                if (hit || age == UPC) begin
                    lit = -1;
                    age = 0;
                end
            end
        end
        m_bprev = b;
        m_lfsr  = lfsr_next(m_lfsr);
    endtask

    task automatic push_expected();
        exp_t e;
        int   t;
        t = (m_state == 0) ? GS : (m_state == 2) ? 0 : GS - play_t / CLK_HZ;
        e.timer = 6'(t);
        e.score = 6'(m_score);
        e.mole  = (lit < 0) ? 4'd0 : 4'(1 << lit);
        e.over  = (m_state == 2);
        e.scen  = 4'(scen);
        q.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic [3:0] b);
        @(negedge clk);
        reset = r;
        start = s;
        btn   = b;
        if (!r) model_reset();
        else    model_edge(s, b);
        push_expected();
    endtask

    task automatic run(input logic s, input logic [3:0] b);
        step(1'b1, s, b);
    endtask

    // Asserts reset between clock edges; one expectation for the async response, one for the next edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        start = 1'b0;
        btn   = 4'd0;
        model_reset();
        push_expected();
        push_expected();
    endtask

    always @(posedge clk or negedge reset) begin
        #1;
        if (q.size() > 0) begin
            got = q.pop_front();
            checks++;
            if (timer !== got.timer || score !== got.score || mole !== got.mole || game_over !== got.over) begin
                errors++;
                $display("FAIL outputs scen%0d t=%0t: timer/score/mole/over got %0d/%0d/%b/%b required %0d/%0d/%b/%b",
                         got.scen, $time, timer, score, mole, game_over,
                         got.timer, got.score, got.mole, got.over);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic       s;
        logic [3:0] b;
        model_reset();

        // Reset then idle; buttons must not matter outside a game.
        scen = 1;
        repeat (3) step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
        repeat (20) run(1'b0, 4'($urandom_range(0, 15)));

        // Untouched game runs out after exactly GS*CLK_HZ cycles.
        scen = 2;
        run(1'b1, 4'd0);
        repeat (34) run(1'b0, 4'd0);

        // Single-cycle hits on each mole.
        scen = 3;
        run(1'b1, 4'd0);
        repeat (34) run(1'b0, (m_bprev == 4'd0 && $urandom_range(0, 3) != 0) ? hit_btn() : 4'd0);

        // Held button, all-buttons press, wrong-button press.
        scen = 4;
        run(1'b1, 4'd0);
        for (int i = 0; i < 20 && lit < 0; i++) run(1'b0, 4'd0);
        b = hit_btn();
        repeat (20) run(1'b0, b);
        run(1'b0, 4'd0);
        for (int i = 0; i < 20 && lit < 0; i++) run(1'b0, 4'd0);
        run(1'b0, 4'hF);
        run(1'b0, 4'd0);
        for (int i = 0; i < 20 && lit < 0; i++) run(1'b0, 4'd0);
        run(1'b0, (lit >= 0) ? 4'(1 << ((lit + 1) % 4)) : 4'd1);
        for (int i = 0; i < 40 && m_state == 1; i++) run(1'b0, 4'd0);

        // Hit on the final second tick, then restart from OVER.
        scen = 5;
        run(1'b1, 4'd0);
        for (int i = 0; i < 40 && play_t < GS * CLK_HZ - 1; i++) run(1'b0, 4'd0);
        run(1'b0, (lit >= 0) ? hit_btn() : 4'hF);
        repeat (2) run(1'b0, 4'd0);
        run(1'b1, 4'd0);
        repeat (3) run(1'b0, 4'd0);

        // Async reset mid-game with score 2 and one second left.
        scen = 6;
        run(1'b1, 4'd0);
        for (int i = 0; i < 30 && m_score < 2; i++) run(1'b0, (m_bprev == 4'd0) ? hit_btn() : 4'd0);
        for (int i = 0; i < 30 && play_t < (GS - 1) * CLK_HZ; i++) run(1'b0, 4'd0);
        async_reset();
        repeat (2) step(1'b0, 1'b0, 4'd0);
        repeat (12) run(1'b0, 4'($urandom_range(0, 15)));

        // Random play with occasional resets.
        scen = 7;
        repeat (500) begin
            if ($urandom_range(0, 249) == 0) begin
                async_reset();
                step(1'b0, 1'b0, 4'd0);
            end
            s = ($urandom_range(0, 39) == 0);
            b = ($urandom_range(0, 1) == 0) ? hit_btn() : 4'($urandom_range(0, 15));
            run(s, b);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
- Game-control core of the whack-a-mole design. Runs the countdown, places moles pseudo-randomly on 4 LEDs, detects hits from debounced buttons, and keeps score.
- Sits directly upstream of the 7-segment display driver. `timer[5:0]` and `score[5:0]` feed it unmodified as 6-bit binary values.

Parameters:
- CLK_HZ, 100_000_000, clock cycles per game second.
- GAME_SECONDS, 30, countdown start value; legal range 1..63.
- MOLE_UP_CYCLES, 75_000_000, cycles a mole stays lit when not hit (≥1).
- MOLE_GAP_CYCLES, 25_000_000, dark cycles between moles (≥1).
- LFSR_SEED, 8'hA5, LFSR value loaded at reset; must be non-zero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  single-cycle pulse from a debounced push-button
- btn  in  4  debounced whack buttons, level-sensitive, btn[i] pairs with mole[i]
- timer  out  6  seconds remaining, binary
- score  out  6  hits this game, binary
- mole  out  4  one-hot lit mole, or 0 when no mole is lit
- game_over  out  1  high while in OVER

Behaviour:

Reset (reset==0):
- state=IDLE, timer=GAME_SECONDS, score=0, mole=0, game_over=0.
- Internal counters = 0, btn_prev=0, lfsr=LFSR_SEED.
- Reset asserted mid-game aborts the game immediately, with no partial update.

All outputs are registered.

State machine IDLE / PLAY / OVER:
- IDLE: timer held at GAME_SECONDS, score=0, mole=0. start=1 → PLAY on the next edge.
- On entering PLAY:
  - timer=GAME_SECONDS, score=0, sec_cnt=0.
  - Mole phase = GAP with gap_cnt=0.
- PLAY seconds: sec_cnt counts 0..CLK_HZ-1. At sec_cnt==CLK_HZ-1 it wraps to 0 and timer decrements.
- PLAY end: when timer==1 and the second tick fires, timer becomes 0 and state → OVER on the same edge. The game therefore lasts exactly GAME_SECONDS*CLK_HZ cycles.
- OVER: timer=0, mole=0, score frozen, game_over=1. start=1 → PLAY with a fresh game; score clears on that entry edge.
- start while in PLAY is ignored.

Mole sub-machine (active only in PLAY):
- GAP phase: mole=0. After MOLE_GAP_CYCLES cycles → UP phase.
- Entering UP: mole is set one-hot at index idx = lfsr[1:0]. If idx equals the previous mole index, use idx+1 mod 4 instead. Consecutive moles never repeat.
- The "previous index" register resets to 0, so the first mole of a game never uses index 0 after reset.
- UP phase ends when either:
  - MOLE_UP_CYCLES have elapsed with no hit → GAP, mole=0, no score change; or
  - a hit occurs → GAP on the next edge, mole=0.

LFSR:
- 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
- Advances every clock in all states; it is never reloaded except by reset.

Hit detection:
- edge = btn & ~btn_prev, where btn_prev is registered every cycle.
- A hit is `|(edge & mole)` while in UP.
- On a hit, score becomes score+1, saturating at 63.
- Several buttons rising in the same cycle score at most +1.
- Wrong-button edges are ignored; there is no penalty.
- A button held high scores only once, on its rising edge.

Simultaneous events:
- A hit on the same cycle as the final second tick is counted: score increments and the state enters OVER on the same edge.
- A mole timeout and a hit on the same cycle count as a hit.
- Outside PLAY, buttons have no effect.

Test Plan:
Parameters for all scenarios: CLK_HZ=10, GAME_SECONDS=3, MOLE_UP_CYCLES=6, MOLE_GAP_CYCLES=2.

1. Reset, then idle 20 cycles → timer=3, score=0, mole=0, game_over=0 throughout.
2. Pulse start, no buttons → timer reads 3,2,1 for 10 cycles each. Exactly 30 cycles after entry: timer=0, game_over=1, mole=0, score=0.
3. Pulse start, then on each UP phase pulse btn matching mole for 1 cycle →
   - score increments by 1 per mole;
   - mole=0 on the cycle after each hit;
   - mole is always one-hot or 0;
   - consecutive mole indices always differ.
4. Hold a matching button for 20 cycles across several moles → only rising edges score. Press btn=4'b1111 on one lit mole → exactly +1. Press only a non-matching button → score unchanged.
5. Align a hit with the final second tick → score increments and game_over=1 on the same edge. Pulse start from OVER → timer=3, score=0 on the next cycle.
6. Drive reset low mid-PLAY with score=2, timer=1 → outputs asynchronously go to timer=3, score=0, mole=0, game_over=0. After release the block stays IDLE until start.
